// File: rtl/top_level_cpu.sv
// Four-stage (IF/OD/EX/WB) 32-bit CPU with a unified 2048x32 program/data memory.
// While halted, the loader port writes memory; while running, the pipeline executes from address 0.
module top_level_cpu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_en,
  input  logic [31:0] w_instruction,
  input  logic        w_enable,
  input  logic [10:0] w_adrs,
  output logic        carry,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    OP_NOP0  = 3'b000,
    OP_NOP1  = 3'b001,
    OP_NOP2  = 3'b010,
    OP_NOP3  = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_STORE = 3'b110,
    OP_LOAD  = 3'b111
  } opcode_e;

  logic [31:0] mem_q [2048];
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [31:0] mem_wdata;

  logic [10:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  opcode_e     ex_op_q, ex_op_d;
  logic [10:0] ex_dst_q, ex_dst_d;
  logic [31:0] ex_a_q, ex_a_d;
  logic [31:0] ex_s_q, ex_s_d;
  logic        ex_imm_q, ex_imm_d;
  logic [31:0] ex_ld_q, ex_ld_d;

  logic        wb_we_q, wb_we_d;
  logic        wb_cy_we_q, wb_cy_we_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic        wb_cy_q, wb_cy_d;

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;

  opcode_e     od_op;
  logic        od_imm;
  logic [10:0] od_dst, od_src;
  logic [31:0] od_immv, od_dst_val, od_src_val, od_ld;
  logic [5:0]  ir_unused;

  logic [32:0] ex_sum, ex_diff;
  logic [31:0] ex_res;
  logic        ex_wr, ex_cy, ex_cy_we;

  always_comb begin
    od_op     = opcode_e'(ir_q[31:29]);
    od_imm    = ir_q[23];
    od_dst    = ir_q[21:11];
    od_src    = ir_q[10:0];
    od_immv   = {21'b0, od_src};
    ir_unused = {ir_q[28:24], ir_q[22]};
  end

  always_comb begin
    ex_sum   = {1'b0, ex_a_q} + {1'b0, ex_s_q};
    ex_diff  = {1'b0, ex_a_q} - {1'b0, ex_s_q};
    ex_res   = '0;
    ex_wr    = 1'b0;
    ex_cy    = 1'b0;
    ex_cy_we = 1'b0;
    case (ex_op_q)
      OP_ADD: begin
        ex_res   = ex_sum[31:0];
        ex_cy    = ex_sum[32];
        ex_wr    = 1'b1;
        ex_cy_we = 1'b1;
      end
      OP_SUB: begin
        ex_res   = ex_diff[31:0];
        ex_cy    = ex_diff[32];
        ex_wr    = 1'b1;
        ex_cy_we = 1'b1;
      end
      OP_LOAD: begin
        ex_res = ex_imm_q ? ex_s_q : ex_ld_q;
        ex_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand read with forwarding: the EX result is newest, then the pending WB value.
  always_comb begin
    od_dst_val = rf_q[od_dst[4:0]];
    if (wb_we_q && wb_dst_q == od_dst[4:0]) od_dst_val = wb_val_q;
    if (ex_wr && ex_dst_q[4:0] == od_dst[4:0]) od_dst_val = ex_res;
    od_src_val = rf_q[od_src[4:0]];
    if (wb_we_q && wb_dst_q == od_src[4:0]) od_src_val = wb_val_q;
    if (ex_wr && ex_dst_q[4:0] == od_src[4:0]) od_src_val = ex_res;
    // A store in EX writes memory on the same edge this read is captured.
    od_ld = mem_q[od_src];
    if (ex_op_q == OP_STORE && ex_dst_q == od_src) od_ld = ex_s_q;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_adrs;
    mem_wdata = w_instruction;
    if (cpu_en) begin
      if (!resetn && ex_op_q == OP_STORE) begin
        mem_we    = 1'b1;
        mem_waddr = ex_dst_q;
        mem_wdata = ex_s_q;
      end
    end else if (w_enable) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ex_op_d    = ex_op_q;
    ex_dst_d   = ex_dst_q;
    ex_a_d     = ex_a_q;
    ex_s_d     = ex_s_q;
    ex_imm_d   = ex_imm_q;
    ex_ld_d    = ex_ld_q;
    wb_we_d    = wb_we_q;
    wb_cy_we_d = wb_cy_we_q;
    wb_dst_d   = wb_dst_q;
    wb_val_d   = wb_val_q;
    wb_cy_d    = wb_cy_q;
    rf_d       = rf_q;
    result_d   = result_q;
    carry_d    = carry_q;
    if (cpu_en) begin
      pc_d       = pc_q + 11'd1;
      ir_d       = mem_q[pc_q];
      ex_op_d    = od_op;
      ex_dst_d   = od_dst;
      ex_a_d     = od_dst_val;
      ex_s_d     = od_imm ? od_immv : od_src_val;
      ex_imm_d   = od_imm;
      ex_ld_d    = od_ld;
      wb_we_d    = ex_wr;
      wb_cy_we_d = ex_cy_we;
      wb_dst_d   = ex_dst_q[4:0];
      wb_val_d   = ex_res;
      wb_cy_d    = ex_cy;
      if (wb_we_q) begin
        rf_d[wb_dst_q] = wb_val_q;
        result_d       = wb_val_q;
      end
      if (wb_cy_we_q) carry_d = wb_cy_q;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ex_op_q    <= OP_NOP0;
      ex_dst_q   <= '0;
      ex_a_q     <= '0;
      ex_s_q     <= '0;
      ex_imm_q   <= 1'b0;
      ex_ld_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_cy_we_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_val_q   <= '0;
      wb_cy_q    <= 1'b0;
      rf_q       <= '{default: '0};
      result_q   <= '0;
      carry_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ex_op_q    <= ex_op_d;
      ex_dst_q   <= ex_dst_d;
      ex_a_q     <= ex_a_d;
      ex_s_q     <= ex_s_d;
      ex_imm_q   <= ex_imm_d;
      ex_ld_q    <= ex_ld_d;
      wb_we_q    <= wb_we_d;
      wb_cy_we_q <= wb_cy_we_d;
      wb_dst_q   <= wb_dst_d;
      wb_val_q   <= wb_val_d;
      wb_cy_q    <= wb_cy_d;
      rf_q       <= rf_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
    end
  end

  always_comb begin
    result = result_q;
    carry  = carry_q;
  end

endmodule

// File: tb/tb_top_level_cpu.sv
// Bench for top_level_cpu: directed programs and random programs checked against
// an instruction-level model of the CPU (sequential semantics plus fetch staleness).
module tb_top_level_cpu;

  logic        clk;
  logic        resetn;
  logic        cpu_en;
  logic [31:0] w_instruction;
  logic        w_enable;
  logic [10:0] w_adrs;
  logic        carry;
  logic [31:0] result;

  top_level_cpu dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en),
    .w_instruction(w_instruction), .w_enable(w_enable), .w_adrs(w_adrs),
    .carry(carry), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] img [2048];
  logic [31:0] mdm [2048];
  logic [31:0] exp_res [256];
  logic        exp_cy [256];
  logic [31:0] cap_res [256];
  logic        cap_cy [256];
  int          cap_idx [256];
  int          n_wall;

  function automatic logic [31:0] enc(input logic [2:0] op, input logic i,
                                      input logic [10:0] dst, input logic [10:0] src);
    return {op, 5'b0, i, 1'b0, dst, src};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [10:0] a, input logic [31:0] d);
    cpu_en = 1'b0;
    w_enable = 1'b1;
    w_adrs = a;
    w_instruction = d;
    tick();
    w_enable = 1'b0;
    img[a] = d;
  endtask

  task automatic wipe();
    for (int a = 0; a < 64; a++) load_word(11'(a), 32'h0);
  endtask

  // Runs instructions 0..n_instr-1 in program order. An instruction fetch does not see
  // stores made by the two instructions just before it; everything else is sequential.
  task automatic run_model(input int n_instr);
    logic [31:0] r [32];
    logic [31:0] res, w, sv, imm, co, h1o, h2o;
    logic [10:0] pa, d, s, ca, h1a, h2a;
    logic        cy, cv, h1v, h2v;
    logic [32:0] wide;
    for (int j = 0; j < 2048; j++) mdm[j] = img[j];
    for (int j = 0; j < 32; j++) r[j] = '0;
    for (int j = 0; j < 3; j++) begin exp_res[j] = '0; exp_cy[j] = 1'b0; end
    res = '0; cy = 1'b0;
    h1v = 1'b0; h2v = 1'b0; h1a = '0; h2a = '0; h1o = '0; h2o = '0;
    for (int a = 0; a < n_instr; a++) begin
      pa = 11'(a);
      w = mdm[pa];
      if (h1v && h1a == pa) w = h1o;
      if (h2v && h2a == pa) w = h2o;
      d = w[21:11];
      s = w[10:0];
      imm = {21'b0, s};
      sv = w[23] ? imm : r[s[4:0]];
      cv = 1'b0; ca = '0; co = '0;
      case (w[31:29])
        3'd4: begin
          wide = {1'b0, r[d[4:0]]} + {1'b0, sv};
          res = wide[31:0]; cy = wide[32]; r[d[4:0]] = res;
        end
        3'd5: begin
          cy = (r[d[4:0]] < sv); res = r[d[4:0]] - sv; r[d[4:0]] = res;
        end
        3'd6: begin
          cv = 1'b1; ca = d; co = mdm[d]; mdm[d] = sv;
        end
        3'd7: begin
          res = w[23] ? imm : mdm[s]; r[d[4:0]] = res;
        end
        default: ;
      endcase
      exp_res[a + 3] = res;
      exp_cy[a + 3] = cy;
      h2v = h1v; h2a = h1a; h2o = h1o;
      h1v = cv;  h1a = ca;  h1o = co;
    end
  endtask

  // Reset, then n enabled edges with an optional freeze window; spurious loader writes
  // are driven on every enabled cycle. Captures outputs only.
  task automatic run_prog(input int n, input int frz_at, input int frz_len);
    int en_cnt;
    run_model(n - 2);
    resetn = 1'b1; cpu_en = 1'b0; w_enable = 1'b0;
    tick();
    resetn = 1'b0;
    en_cnt = 0;
    for (int t = 0; t < n + frz_len; t++) begin
      cpu_en = !(t >= frz_at && t < frz_at + frz_len);
      w_enable = cpu_en;
      w_adrs = 11'($urandom_range(0, 2047));
      w_instruction = $urandom();
      tick();
      if (cpu_en) en_cnt++;
      cap_res[t] = result;
      cap_cy[t] = carry;
      cap_idx[t] = en_cnt - 1;
    end
    n_wall = n + frz_len;
    cpu_en = 1'b0;
    w_enable = 1'b0;
    for (int j = 0; j < 2048; j++) img[j] = mdm[j];
  endtask

  task automatic test_reset();
    resetn = 1'b1; cpu_en = 1'b1; w_enable = 1'b0;
    tick();
    n_cmp++;
    if (result !== 32'h0 || carry !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state result=%h carry=%b expected result=00000000 carry=0", result, carry);
    end
    cpu_en = 1'b0;
  endtask

  task automatic test_basic();
    wipe();
    load_word(11'd1, 32'hE0001807);
    load_word(11'd4, 32'hC07FF803);
    load_word(11'd6, 32'h80801801);
    load_word(11'd7, 32'h12345678);
    load_word(11'd8, enc(3'd7, 1'b0, 11'd5, 11'd2047));
    run_prog(14, 0, 0);
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL basic_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
    n_cmp++;
    if (cap_res[4] !== 32'h12345678) begin
      n_bad++; $display("FAIL basic_load result=%h expected 12345678", cap_res[4]);
    end
    n_cmp++;
    if (cap_res[9] !== 32'h12345679 || cap_cy[9] !== 1'b0) begin
      n_bad++; $display("FAIL basic_add result=%h carry=%b expected 12345679/0", cap_res[9], cap_cy[9]);
    end
    n_cmp++;
    if (cap_res[11] !== 32'h12345678) begin
      n_bad++; $display("FAIL basic_store_2047 result=%h expected 12345678", cap_res[11]);
    end
  endtask

  task automatic test_carry();
    wipe();
    load_word(11'd300, 32'hFFFFFFFF);
    load_word(11'd0, enc(3'd7, 1'b0, 11'd1, 11'd300));
    load_word(11'd1, enc(3'd4, 1'b1, 11'd1, 11'd1));
    run_prog(8, 0, 0);
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL carry_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
    n_cmp++;
    if (cap_res[4] !== 32'h0 || cap_cy[4] !== 1'b1) begin
      n_bad++; $display("FAIL carry_out result=%h carry=%b expected 00000000/1", cap_res[4], cap_cy[4]);
    end
  endtask

  task automatic test_borrow();
    wipe();
    load_word(11'd0, enc(3'd7, 1'b1, 11'd2, 11'd5));
    load_word(11'd1, enc(3'd5, 1'b1, 11'd2, 11'd7));
    load_word(11'd2, enc(3'd5, 1'b1, 11'd2, 11'd1));
    run_prog(8, 0, 0);
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL borrow_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
    n_cmp++;
    if (cap_res[4] !== 32'hFFFFFFFE || cap_cy[4] !== 1'b1) begin
      n_bad++; $display("FAIL borrow_set result=%h carry=%b expected fffffffe/1", cap_res[4], cap_cy[4]);
    end
    n_cmp++;
    if (cap_res[5] !== 32'hFFFFFFFD || cap_cy[5] !== 1'b0) begin
      n_bad++; $display("FAIL borrow_clr result=%h carry=%b expected fffffffd/0", cap_res[5], cap_cy[5]);
    end
  endtask

  task automatic load_fwd_prog(input logic [10:0] base);
    load_word(11'd301, 32'd10);
    load_word(base + 11'd0, enc(3'd7, 1'b0, 11'd4, 11'd301));
    load_word(base + 11'd1, enc(3'd4, 1'b0, 11'd4, 11'd4));
    load_word(base + 11'd2, enc(3'd4, 1'b1, 11'd4, 11'd1));
    load_word(base + 11'd3, enc(3'd6, 1'b0, 11'd302, 11'd4));
    load_word(base + 11'd4, enc(3'd7, 1'b0, 11'd6, 11'd302));
  endtask

  task automatic test_forwarding();
    logic [31:0] want [4];
    int          at [4];
    wipe();
    load_fwd_prog(11'd0);
    run_prog(10, 0, 0);
    want[0] = 32'd10; want[1] = 32'd20; want[2] = 32'd21; want[3] = 32'd21;
    at[0] = 3; at[1] = 4; at[2] = 5; at[3] = 7;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (cap_res[at[j]] !== want[j]) begin
        n_bad++;
        $display("FAIL fwd_seq idx=%0d result=%h expected %h", j, cap_res[at[j]], want[j]);
      end
    end
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL fwd_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
  endtask

  task automatic test_freeze();
    wipe();
    load_word(11'd0, enc(3'd7, 1'b1, 11'd2, 11'd5));
    load_word(11'd1, enc(3'd5, 1'b1, 11'd2, 11'd7));
    load_word(11'd2, enc(3'd5, 1'b1, 11'd2, 11'd1));
    load_fwd_prog(11'd3);
    run_prog(16, 5, 5);
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL freeze_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
    n_cmp++;
    if (cap_res[n_wall - 1] !== 32'd21) begin
      n_bad++; $display("FAIL freeze_final result=%h expected 00000015", cap_res[n_wall - 1]);
    end
  endtask

  task automatic test_reset_midrun();
    wipe();
    load_word(11'd2047, 32'hCAFEF00D);
    load_word(11'd0, enc(3'd7, 1'b0, 11'd7, 11'd2047));
    load_word(11'd1, enc(3'd6, 1'b1, 11'd2047, 11'h155));
    run_prog(6, 0, 0);
    n_cmp++;
    if (cap_res[3] !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL midrun_first result=%h expected cafef00d", cap_res[3]);
    end
    resetn = 1'b1; cpu_en = 1'b1; w_enable = 1'b0;
    tick();
    n_cmp++;
    if (result !== 32'h0 || carry !== 1'b0) begin
      n_bad++; $display("FAIL midrun_reset result=%h carry=%b expected 00000000/0", result, carry);
    end
    cpu_en = 1'b0;
    run_prog(6, 0, 0);
    n_cmp++;
    if (cap_res[3] !== 32'h00000155) begin
      n_bad++; $display("FAIL midrun_rerun result=%h expected 00000155", cap_res[3]);
    end
    for (int t = 0; t < n_wall; t++) begin
      n_cmp++;
      if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
        n_bad++;
        $display("FAIL midrun_trace t=%0d result=%h carry=%b expected result=%h carry=%b",
                 t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
      end
    end
  endtask

  function automatic logic [10:0] pick_field();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 11'(96 + $urandom_range(0, 7));
    else if (r < 9) return 11'($urandom_range(0, 60));
    else return 11'($urandom_range(0, 2047));
  endfunction

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      wipe();
      for (int j = 96; j < 104; j++) load_word(11'(j), $urandom());
      for (int a = 0; a < 48; a++) begin
        int r;
        logic [2:0] op;
        r = $urandom_range(0, 9);
        op = (r < 2) ? 3'(r) : 3'(4 + r % 4);
        load_word(11'(a), enc(op, 1'($urandom_range(0, 1)), pick_field(), pick_field()));
      end
      run_prog(56, $urandom_range(1, 40), $urandom_range(0, 6));
      for (int t = 0; t < n_wall; t++) begin
        n_cmp++;
        if (cap_res[t] !== exp_res[cap_idx[t]] || cap_cy[t] !== exp_cy[cap_idx[t]]) begin
          n_bad++;
          $display("FAIL random_trace it=%0d t=%0d result=%h carry=%b expected result=%h carry=%b",
                   it, t, cap_res[t], cap_cy[t], exp_res[cap_idx[t]], exp_cy[cap_idx[t]]);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b1;
    cpu_en = 1'b0;
    w_enable = 1'b0;
    w_adrs = '0;
    w_instruction = '0;
    for (int a = 0; a < 2048; a++) load_word(11'(a), 32'h0);
    test_reset();
    test_basic();
    test_carry();
    test_borrow();
    test_forwarding();
    test_freeze();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/top_level_cpu.md
# top_level_cpu

Small 4-stage pipelined 32-bit CPU with a unified 2048×32 memory that holds both program and data. While halted (`cpu_en=0`) an external loader writes words into memory. While running, the CPU executes from address 0 upward. The CPU exposes the most recent register write-back value and the ALU carry flag. It is the top of the CPU hierarchy, driven directly by the system bench/host.

## Interface
- No parameters. Memory depth is fixed at 2048 words × 32 bits, with an 11-bit address.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `resetn` in 1 — synchronous reset, active-high.
- `cpu_en` in 1 — 1 runs the pipeline; 0 freezes it and enables loading.
- `w_instruction` in 32 — loader write data.
- `w_enable` in 1 — loader write strobe.
- `w_adrs` in 11 — loader write address.
- `carry` out 1 — carry/borrow flag of the last ADD/SUB.
- `result` out 32 — value of the last register write-back.

## Operation
- **Instruction fields**
  - `[31:29]` opcode.
  - `[28:24]` reserved; ignored.
  - `[23]` I: source is an immediate.
  - `[22]` ignored.
  - `[21:11]` DST (11 bits).
  - `[10:0]` SRC (11 bits).
- **Register file:** 32×32, index = low 5 bits of the field.
- **Immediate:** SRC zero-extended to 32 bits.
- **S value:** S = I ? imm : R[SRC].
- **Opcodes**
  - 000–011: NOP. All-zero words and raw data words with top bits 000 execute harmlessly.
  - 100 ADD: R[DST] ← R[DST] + S; `carry` ← bit 32 of the sum.
  - 101 SUB: R[DST] ← R[DST] − S; `carry` ← 1 iff borrow (R[DST] < S, unsigned).
  - 110 STORE: mem[DST] ← S (full 11-bit address). No register write; `result`/`carry` unchanged.
  - 111 LOAD: R[DST] ← I ? imm : mem[SRC]. `carry` unchanged.
- **Pipeline stages:** IF (mem[PC]→IR, PC+1) → OD (decode, register read, data-memory read issue) → EX (ALU, load data capture, store write) → WB (register write, `result` ← written value, `carry` update for ADD/SUB).
- **Forwarding:** full forwarding from EX and WB into OD, so back-to-back dependent instructions (including LOAD→use) never stall and see the newest value.
- **Store→load bypass:** a LOAD immediately following a STORE to the same address returns the stored value.
- **No store→fetch forwarding:** a STORE into an address fetched within the next 2 cycles leaves the old word in flight.
- **PC:** wraps 2047→0.
- **Loader:** when `cpu_en=0` and `w_enable=1`, mem[`w_adrs`] ← `w_instruction` at the clock edge. This is honoured also during reset. With `cpu_en=1`, `w_enable` is ignored.
- **Reset (`resetn=1`):**
  - PC=0; all registers 0; all pipeline stages hold NOP.
  - `result`=0; `carry`=0.
  - Memory contents are preserved.
- **`cpu_en=0` while running:** PC, pipeline registers, register file, `result` and `carry` all hold; execution resumes exactly where it stopped.

## Timing
- Let edge k be the first enabled edge after reset. Word at address a is fetched at edge k+a.
- An instruction at address a writes back (`result`/`carry` visible) after edge k+a+3.
- A STORE at address a writes memory at edge k+a+2.
- Throughput: one instruction per enabled cycle; no stalls in any case.
- Reset has priority over `cpu_en`.
- Outputs are registered and change only at clock edges.

## Test plan
- **Basic program.** Load mem[1]=LOAD R3←mem[7] (0xE0001807), mem[4]=STORE mem[2047]←R3 (0xC07FF803), mem[6]=ADD R3+=imm 1 (0x80801801), mem[7]=0x12345678. Then set `cpu_en=1`.
  - `result`=0x12345678 after edge k+4.
  - mem[2047]=0x12345678.
  - `result`=0x12345679, `carry`=0 after edge k+9.
- **Carry.** LOAD R1←imm via memory word 0xFFFFFFFF, then ADD R1 += imm 1 → `result`=0, `carry`=1.
- **Borrow.** R2=5; SUB R2 −= imm 7 → `result`=0xFFFFFFFE, `carry`=1. A following SUB R2 −= imm 1 → 0xFFFFFFFD, `carry`=0.
- **Forwarding.** Consecutive LOAD R4←mem[x]=10; ADD R4+=R4; ADD R4+=imm 1 with no NOPs between them → `result` sequence 10, 20, 21.
- **Freeze.** Drop `cpu_en` for 5 cycles mid-program → outputs frozen; on resume, the final values equal those of an uninterrupted run.
- **Reset mid-run.** Assert `resetn` mid-run → `result`=0, `carry`=0. After release, the program reruns from address 0 with memory intact (mem[2047] keeps its stored value).
